uart_xmit: RTL

- Byte-serial UART transmitter, 8N1 (1 start, 8 data LSB-first, 1 stop), idle-high line.
- Sits between the result/coordinate logic and the FPGA TX pin; returns data to the laptop at the same bit rate the receiver uses (217 clocks per bit).
- Upstream sees a valid/ready byte handshake; downstream sees only the serial line.

---
 rtl/uart_pkg.sv | 9 +
 rtl/uart_baud_tick.sv | 35 +++
 rtl/uart_xmit.sv | 122 ++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame geometry and default bit rate.
package uart_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

  localparam int UART_DATA_BITS    = 8;
  localparam int UART_CLKS_PER_BIT = 217;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while run is high and pulses bit_end on the last count.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 217
) (
  input  logic clock,
  input  logic reset,
  input  logic run,
  input  logic restart,
  output logic bit_end
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);

  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;

  assign bit_end = run && (count_reg == CNT_W'(CLKS_PER_BIT - 1));

  // Wrapping at bit_end keeps every bit exactly CLKS_PER_BIT long with no drift.
  always_comb begin
    count_next = count_reg + CNT_W'(1);
    if (restart || !run || bit_end) begin
      count_next = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

endmodule

// File: rtl/uart_xmit.sv
// 8N1 UART transmitter with valid/ready byte input and registered idle-high line.
// Define UART_CTS_EN to gate acceptance on a synchronised uart_cts input.
module uart_xmit
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      uart_data_valid,
  input  logic [UART_DATA_BITS-1:0] uart_data,
  output logic                      uart_data_ready,
  output logic                      uart_tx,
  output logic                      uart_busy,
  output logic                      uart_tx_done,
  input  logic                      uart_cts
);

  localparam int BIT_W = $clog2(UART_DATA_BITS);

  uart_state_t               state_reg, state_next;
  logic [UART_DATA_BITS-1:0] shift_reg, shift_next;
  logic [BIT_W-1:0]          bit_cnt_reg, bit_cnt_next;
  logic                      tx_reg, tx_next;
  logic                      cts_ok;
  logic                      accept;
  logic                      bit_end;

`ifdef UART_CTS_EN
  logic cts_meta_reg;
  logic cts_sync_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      cts_meta_reg <= 1'b0;
      cts_sync_reg <= 1'b0;
    end else begin
      cts_meta_reg <= uart_cts;
      cts_sync_reg <= cts_meta_reg;
    end
  end

  assign cts_ok = cts_sync_reg;
`else
  logic unused_cts;
  assign unused_cts = uart_cts;
  assign cts_ok     = 1'b1;
`endif

  assign uart_data_ready = (state_reg == IDLE) && cts_ok;
  assign accept          = uart_data_valid && uart_data_ready;
  assign uart_busy       = (state_reg != IDLE);
  assign uart_tx_done    = (state_reg == STOP) && bit_end;
  assign uart_tx         = tx_reg;

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_tick (
    .clock  (clock),
    .reset  (reset),
    .run    (uart_busy),
    .restart(accept),
    .bit_end(bit_end)
  );

  always_comb begin
    state_next   = state_reg;
    shift_next   = shift_reg;
    bit_cnt_next = bit_cnt_reg;
    unique case (state_reg)
      IDLE: begin
        if (accept) begin
          shift_next = uart_data;
          state_next = START;
        end
      end
      START: begin
        if (bit_end) begin
          bit_cnt_next = '0;
          state_next   = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_next   = shift_reg >> 1;
          bit_cnt_next = bit_cnt_reg + BIT_W'(1);
          if (bit_cnt_reg == BIT_W'(UART_DATA_BITS - 1)) begin
            state_next = STOP;
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    // Line level is derived from the upcoming state so uart_tx stays a pure register.
    unique case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[0];
      default: tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg   <= IDLE;
      shift_reg   <= '0;
      bit_cnt_reg <= '0;
      tx_reg      <= 1'b1;
    end else begin
      state_reg   <= state_next;
      shift_reg   <= shift_next;
      bit_cnt_reg <= bit_cnt_next;
      tx_reg      <= tx_next;
    end
  end

endmodule
